// File: rtl/otter_cu_fsm.sv
// OTTER multicycle control FSM: fetch / exec / load writeback / interrupt entry.
// Drives the write strobes and keeps the retired-instruction count for the CSR unit.
module otter_cu_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 CU_CLK,
  input  logic                 CU_RESET,
  input  logic [6:0]           CU_OPCODE,
  input  logic [2:0]           CU_FUNC3,
  input  logic                 CU_INT,
  input  logic                 CU_MIE,
  output logic                 CU_PCWRITE,
  output logic                 CU_REGWRITE,
  output logic                 CU_MEMWRITE,
  output logic                 CU_MEMREAD1,
  output logic                 CU_MEMREAD2,
  output logic                 CU_intTaken,
  output logic                 CU_csrWrite,
  output logic                 CU_MRET,
  output logic [1:0]           CU_STATE,
  output logic [INSTRET_W-1:0] CU_INSTRET
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_WB    = 2'd2,
    ST_INTR  = 2'd3
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;

  localparam logic [INSTRET_W-1:0] ONE = {{(INSTRET_W-1){1'b0}}, 1'b1};

  state_t               r_state;
  state_t               w_next;
  logic [INSTRET_W-1:0] r_instret;
  logic                 w_is_load;
  logic                 w_sys_csr;
  logic                 w_sys_mret;
  logic                 w_irq;
  logic                 w_retire;

  assign w_is_load  = (CU_OPCODE == OP_LOAD);
  assign w_sys_mret = (CU_OPCODE == OP_SYSTEM) && (CU_FUNC3 == 3'b000);
  assign w_sys_csr  = (CU_OPCODE == OP_SYSTEM) &&
                      (CU_FUNC3 != 3'b000) && (CU_FUNC3 != 3'b100);
  assign w_irq      = CU_INT && CU_MIE;

  // A reset cycle never retires the instruction it interrupts.
  assign w_retire = !CU_RESET &&
                    (((r_state == ST_EXEC) && !w_is_load) ||
                     (r_state == ST_WB));

  always_ff @(posedge CU_CLK) begin
    if (CU_RESET) begin
      r_state   <= ST_FETCH;
      r_instret <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire)
        r_instret <= r_instret + ONE;
    end
  end

  always_comb begin
    w_next = ST_FETCH;
    unique case (r_state)
      ST_FETCH: w_next = ST_EXEC;
      ST_EXEC: begin
        if (w_is_load)  w_next = ST_WB;
        else if (w_irq) w_next = ST_INTR;
        else            w_next = ST_FETCH;
      end
      ST_WB:   w_next = w_irq ? ST_INTR : ST_FETCH;
      ST_INTR: w_next = ST_FETCH;
    endcase
  end

  always_comb begin
    CU_PCWRITE  = 1'b0;
    CU_REGWRITE = 1'b0;
    CU_MEMWRITE = 1'b0;
    CU_MEMREAD1 = 1'b0;
    CU_MEMREAD2 = 1'b0;
    CU_intTaken = 1'b0;
    CU_csrWrite = 1'b0;
    CU_MRET     = 1'b0;
    if (!CU_RESET) begin
      unique case (r_state)
        ST_FETCH: CU_MEMREAD1 = 1'b1;
        ST_EXEC: begin
          CU_PCWRITE = 1'b1;
          case (CU_OPCODE)
            OP_LUI, OP_AUIPC, OP_JAL,
            OP_JALR, OP_OP, OP_IMM:
              CU_REGWRITE = 1'b1;
            OP_SYSTEM: begin
              CU_REGWRITE = w_sys_csr;
              CU_csrWrite = w_sys_csr;
              CU_MRET     = w_sys_mret;
            end
            OP_STORE: CU_MEMWRITE = 1'b1;
            OP_LOAD:  CU_MEMREAD2 = 1'b1;
            default:  ;
          endcase
        end
        ST_WB:   CU_REGWRITE = 1'b1;
        ST_INTR: begin
          CU_intTaken = 1'b1;
          CU_PCWRITE  = 1'b1;
        end
      endcase
    end
  end

  assign CU_STATE   = r_state;
  assign CU_INSTRET = r_instret;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm (INSTRET_W=4).
// Strobe vector: {pcw,regw,memw,mr1,mr2,int,csr,mret}.
module tb_otter_cu_fsm;

  logic       clk;
  logic       rst;
  logic [6:0] opc;
  logic [2:0] f3;
  logic       irq;
  logic       mie;
  logic       pcw, regw, memw, mr1, mr2, itk, csrw, mret;
  logic [1:0] st;
  logic [3:0] instret;

  int errs;
  int checks;
  int ir;

  otter_cu_fsm #(.INSTRET_W(4)) dut (
    .CU_CLK     (clk),
    .CU_RESET   (rst),
    .CU_OPCODE  (opc),
    .CU_FUNC3   (f3),
    .CU_INT     (irq),
    .CU_MIE     (mie),
    .CU_PCWRITE (pcw),
    .CU_REGWRITE(regw),
    .CU_MEMWRITE(memw),
    .CU_MEMREAD1(mr1),
    .CU_MEMREAD2(mr2),
    .CU_intTaken(itk),
    .CU_csrWrite(csrw),
    .CU_MRET    (mret),
    .CU_STATE   (st),
    .CU_INSTRET (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag,
                      input logic [1:0] es,
                      input logic [7:0] eb,
                      input logic [3:0] ei);
    #1;
    check({tag, ".state"}, {30'd0, st}, {30'd0, es});
    check({tag, ".stb"},
          {24'd0, pcw, regw, memw, mr1, mr2, itk, csrw, mret},
          {24'd0, eb});
    check({tag, ".instret"}, {28'd0, instret}, {28'd0, ei});
    @(posedge clk);
    #1;
  endtask

  localparam logic [6:0] ADDI  = 7'b0010011;
  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] SYS   = 7'b1110011;

  initial begin
    errs = 0; checks = 0; ir = 0;
    rst = 1'b1; opc = ADDI; f3 = 3'd0; irq = 1'b0; mie = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step("rst", 2'd0, 8'h00, 4'd0);
    rst = 1'b0;

    step("addi0.f", 2'd0, 8'h10, 4'd0);
    step("addi0.e", 2'd1, 8'hC0, 4'd0);
    step("addi1.f", 2'd0, 8'h10, 4'd1);
    step("addi1.e", 2'd1, 8'hC0, 4'd1);

    opc = LW;
    step("lw.f", 2'd0, 8'h10, 4'd2);
    step("lw.e", 2'd1, 8'h88, 4'd2);
    step("lw.wb", 2'd2, 8'h40, 4'd2);

    opc = SW;
    step("sw.f", 2'd0, 8'h10, 4'd3);
    irq = 1'b1; mie = 1'b1;
    step("sw.e", 2'd1, 8'hA0, 4'd3);
    irq = 1'b0;
    step("sw.int", 2'd3, 8'h84, 4'd4);

    opc = ADDI;
    step("nomie.f", 2'd0, 8'h10, 4'd4);
    irq = 1'b1; mie = 1'b0;
    step("nomie.e", 2'd1, 8'hC0, 4'd4);
    irq = 1'b1; mie = 1'b1;
    step("fpulse.f", 2'd0, 8'h10, 4'd5);
    irq = 1'b0;
    step("fpulse.e", 2'd1, 8'hC0, 4'd5);

    opc = LW;
    step("lwx.f", 2'd0, 8'h10, 4'd6);
    irq = 1'b1;
    step("lwx.e", 2'd1, 8'h88, 4'd6);
    irq = 1'b0;
    step("lwx.wb", 2'd2, 8'h40, 4'd6);
    step("lwi.f", 2'd0, 8'h10, 4'd7);
    step("lwi.e", 2'd1, 8'h88, 4'd7);
    irq = 1'b1;
    step("lwi.wb", 2'd2, 8'h40, 4'd7);
    irq = 1'b0;
    step("lwi.int", 2'd3, 8'h84, 4'd8);

    opc = SYS; f3 = 3'b001;
    step("csr.f", 2'd0, 8'h10, 4'd8);
    step("csr.e", 2'd1, 8'hC2, 4'd8);
    f3 = 3'b000;
    step("mret.f", 2'd0, 8'h10, 4'd9);
    step("mret.e", 2'd1, 8'h81, 4'd9);
    f3 = 3'b100;
    step("sys4.f", 2'd0, 8'h10, 4'd10);
    step("sys4.e", 2'd1, 8'h80, 4'd10);
    opc = 7'b0000000; f3 = 3'b000;
    step("unk.f", 2'd0, 8'h10, 4'd11);
    step("unk.e", 2'd1, 8'h80, 4'd11);

    opc = ADDI;
    ir = 12;
    for (int i = 0; i < 4; i++) begin
      step("wrap.f", 2'd0, 8'h10, 4'(ir));
      step("wrap.e", 2'd1, 8'hC0, 4'(ir));
      ir++;
    end
    step("wrap0.f", 2'd0, 8'h10, 4'd0);
    step("wrap0.e", 2'd1, 8'hC0, 4'd0);

    opc = LW;
    step("rlw.f", 2'd0, 8'h10, 4'd1);
    step("rlw.e", 2'd1, 8'h88, 4'd1);
    rst = 1'b1; irq = 1'b1;
    step("rlw.wb", 2'd2, 8'h00, 4'd1);
    step("rlw.rst", 2'd0, 8'h00, 4'd0);
    rst = 1'b0; irq = 1'b0; opc = ADDI;
    step("post.f", 2'd0, 8'h10, 4'd0);
    step("post.e", 2'd1, 8'hC0, 4'd0);
    step("post.f2", 2'd0, 8'h10, 4'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/otter_cu_fsm.md
# otter_cu_fsm

Multicycle control state machine for the OTTER RV32I core with 1-cycle memory. It sequences fetch, execute, load writeback and interrupt entry, and it drives the register-file, memory, PC and CSR write strobes. It generates `CU_intTaken`, which the combinational CU decoder uses to force the interrupt PC source. A retired-instruction counter is also provided for the CSR unit.

## Interface
Parameters:
- `INSTRET_W`, default 32: width of the retired-instruction counter.

Ports:
- `CU_CLK`, in, 1: single clock; all state updates on the rising edge.
- `CU_RESET`, in, 1: reset, synchronous and active-high.
- `CU_OPCODE`, in, 7: instruction opcode, valid from EXEC onward.
- `CU_FUNC3`, in, 3: instruction funct3.
- `CU_INT`, in, 1: level interrupt request.
- `CU_MIE`, in, 1: interrupt enable from the CSR unit.
- `CU_PCWRITE`, out, 1: PC register load.
- `CU_REGWRITE`, out, 1: register-file write.
- `CU_MEMWRITE`, out, 1: data memory write.
- `CU_MEMREAD1`, out, 1: instruction fetch read.
- `CU_MEMREAD2`, out, 1: data memory read.
- `CU_intTaken`, out, 1: interrupt entry; PC loads the trap vector and the CSR unit saves the PC.
- `CU_csrWrite`, out, 1: CSR write strobe.
- `CU_MRET`, out, 1: mret executed; the CSR unit restores MIE.
- `CU_STATE`, out, 2: current state. FETCH=0, EXEC=1, WRITEBACK=2, INTERRUPT=3.
- `CU_INSTRET`, out, INSTRET_W: retired-instruction count.

## Operation
States and outputs. Any strobe not listed for a state is 0 in that state.
- FETCH:
  - `CU_MEMREAD1`=1.
  - Next state is always EXEC.
- EXEC:
  - `CU_PCWRITE`=1 for every opcode.
  - `CU_REGWRITE`=1 for LUI (0110111), AUIPC (0010111), JAL (1101111), JALR (1100111), OP (0110011) and OP_IMM (0010011). Also 1 for SYSTEM (1110011) with funct3 in {001,010,011,101,110,111}.
  - `CU_csrWrite`=1 for SYSTEM with the same funct3 set. The rs1=x0 / zimm=0 no-write case is not special-cased.
  - `CU_MRET`=1 for SYSTEM with funct3=000.
  - `CU_MEMWRITE`=1 for STORE (0100011).
  - `CU_MEMREAD2`=1 for LOAD (0000011).
  - BRANCH asserts only `CU_PCWRITE`. The decoder chooses the target.
  - Unknown opcodes and SYSTEM funct3=100 execute as NOP: only `CU_PCWRITE`.
  - Next state:
    - LOAD goes to WRITEBACK.
    - Otherwise, `CU_INT && CU_MIE` goes to INTERRUPT.
    - Otherwise FETCH.
- WRITEBACK:
  - `CU_REGWRITE`=1.
  - Next state is INTERRUPT if `CU_INT && CU_MIE`, else FETCH.
- INTERRUPT:
  - `CU_intTaken`=1 and `CU_PCWRITE`=1.
  - Next state is always FETCH.
- Interrupt sampling:
  - The interrupt is sampled only in the last cycle of an instruction: EXEC for non-loads, WRITEBACK for loads.
  - A pulse on `CU_INT` outside those cycles is ignored; there is no pending latch.
  - The interrupted instruction completes and retires first.
  - The MIE clear on entry is the CSR unit's job, so back-to-back INTERRUPT states are impossible: INTERRUPT always passes through FETCH and EXEC.
- Retired-instruction counter:
  - `CU_INSTRET` increments by 1 on the edge ending EXEC for non-loads, and on the edge ending WRITEBACK for loads.
  - INTERRUPT cycles do not count.
  - Wraps from 2^INSTRET_W−1 to 0 with no flag.
- Reset:
  - While `CU_RESET`=1 at an edge, the state goes to FETCH and `CU_INSTRET` goes to 0.
  - While `CU_RESET` is high, all strobes are forced to 0 combinationally, including `CU_MEMREAD1`. `CU_STATE` still reports the registered state.
  - Reset asserted mid-instruction (EXEC, WRITEBACK or INTERRUPT) suppresses that cycle's writes, and the instruction does not retire.
  - Reset has priority over the interrupt.

## Timing
- Reset values: state FETCH (`CU_STATE`=0), `CU_INSTRET`=0, all strobes 0.
- First `CU_MEMREAD1` appears in the first cycle with `CU_RESET` low.
- Strobes are combinational from the registered state and opcode, and are valid within the same cycle.
- Instruction latency:
  - 2 cycles for non-loads (FETCH, EXEC).
  - 3 cycles for loads (FETCH, EXEC, WRITEBACK).
  - Plus 1 cycle if an interrupt is taken.
- `CU_INSTRET` updates at the same edge that leaves the retiring state, so it is visible in the following cycle.

## Test plan
- Reset held for 3 cycles, then released:
  - During reset, all strobes are 0 and `CU_INSTRET`=0.
  - `CU_STATE` sequence after release is 0,1,0,1 for ADDI (0010011) fetched repeatedly.
  - `CU_INSTRET`=2 after the 4th cycle.
- LW (0000011), `CU_INT`=0:
  - States 0,1,2,0.
  - `CU_MEMREAD2`=1 only in EXEC.
  - `CU_REGWRITE`=1 only in WRITEBACK.
  - `CU_INSTRET` increments once, after WRITEBACK.
- SW (0100011) with `CU_INT`=1 and `CU_MIE`=1 in EXEC:
  - States 0,1,3,0.
  - `CU_MEMWRITE`=1 in EXEC.
  - `CU_intTaken`=1 and `CU_PCWRITE`=1 in INTERRUPT.
  - `CU_INSTRET`+1.
- Interrupt gating:
  - `CU_INT`=1, `CU_MIE`=0 during EXEC: no INTERRUPT state.
  - `CU_INT` pulsed only during FETCH: ignored.
  - LW with `CU_INT`=1 in EXEC only: no interrupt; it must be present in WRITEBACK.
- SYSTEM:
  - funct3=001: `CU_REGWRITE`=1 and `CU_csrWrite`=1 in EXEC.
  - funct3=000: `CU_MRET`=1, `CU_REGWRITE`=0.
  - Opcode 0000000: only `CU_PCWRITE`.
- Counter wrap and reset mid-operation, with INSTRET_W=4:
  - 16 retirements: 15 → 0.
  - Assert `CU_RESET` in WRITEBACK of a LW: `CU_REGWRITE`=0 that cycle, next state 0, `CU_INSTRET`=0.
